// File: rtl/divider_u_seq.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Quotient on y, remainder on z; start/done handshake with busy.
module divider_u_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_r, w_r_n;
  logic [WIDTH-1:0] r_q, w_q_n;
  logic [WIDTH-1:0] r_d, w_d_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_zero, w_zero_n;
  logic [WIDTH-1:0] r_y, w_y_n;
  logic [WIDTH-1:0] r_z, w_z_n;
  logic             r_done, w_done_n;
  logic             r_dbz, w_dbz_n;
  logic [WIDTH:0]   w_t;

  // R never exceeds D after a step, so its top bit is always 0 and is not kept
  assign w_t = {r_r, r_q[WIDTH-1]} - {1'b0, r_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_y     <= '0;
      r_z     <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_r     <= w_r_n;
      r_q     <= w_q_n;
      r_d     <= w_d_n;
      r_cnt   <= w_cnt_n;
      r_zero  <= w_zero_n;
      r_y     <= w_y_n;
      r_z     <= w_z_n;
      r_done  <= w_done_n;
      r_dbz   <= w_dbz_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_r_n     = r_r;
    w_q_n     = r_q;
    w_d_n     = r_d;
    w_cnt_n   = r_cnt;
    w_zero_n  = r_zero;
    w_y_n     = r_y;
    w_z_n     = r_z;
    w_done_n  = 1'b0;
    w_dbz_n   = r_dbz;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_q_n     = a1;
          w_d_n     = b1;
          w_r_n     = '0;
          w_cnt_n   = '0;
          w_zero_n  = (b1 == '0);
          w_state_n = RUN;
        end
      end
      RUN: begin
        // a zero divisor spends one settle cycle here without iterating
        if (r_zero) begin
          w_state_n = FIN;
        end else begin
          if (!w_t[WIDTH]) begin
            w_r_n = w_t[WIDTH-1:0];
            w_q_n = {r_q[WIDTH-2:0], 1'b1};
          end else begin
            w_r_n = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
            w_q_n = {r_q[WIDTH-2:0], 1'b0};
          end
          w_cnt_n = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1))
            w_state_n = FIN;
        end
      end
      FIN: begin
        w_state_n = IDLE;
        w_done_n  = 1'b1;
        if (r_zero) begin
          w_y_n   = '1;
          w_z_n   = r_q;
          w_dbz_n = 1'b1;
        end else begin
          w_y_n   = r_q;
          w_z_n   = r_r;
          w_dbz_n = 1'b0;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign y           = r_y;
  assign z           = r_z;
  assign div_by_zero = r_dbz;

endmodule
